// File: rtl/sub_seq_64_if.sv
// Operand/result bundle for the sequential subtractor.
// The master drives the operands and start; the slave returns status and results.
interface sub_seq_64_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/sub_seq_64.sv
// Ripple-borrow subtractor (diff = a - b - bin), one CHUNK-bit slice per clock.
// Define SUB_SEQ_OVF_EN to compute signed overflow; otherwise ovf is tied to 0.
module sub_seq_64 #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst,
   sub_seq_64_if.slave  bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             borrow_q;
   logic [WIDTH-1:0] diff_q;
   logic             busy_q;
   logic             done_q;
   logic             bout_q;

   logic [CHUNK-1:0] a_sl [N];
   logic [CHUNK-1:0] b_sl [N];
   logic [CHUNK-1:0] a_cur;
   logic [CHUNK-1:0] b_cur;
   logic [CHUNK:0]   sum_d;
   logic             last_slice;

   for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_sl[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_sl[gi] = b_q[gi*CHUNK +: CHUNK];
   end

   assign a_cur      = a_sl[cnt_q];
   assign b_cur      = b_sl[cnt_q];
   // Subtraction as a + ~b + ~borrow; carry-out low means a borrow into the next slice.
   assign sum_d      = {1'b0, a_cur} + {1'b0, ~b_cur} + {{CHUNK{1'b0}}, ~borrow_q};
   assign last_slice = (cnt_q == CW'(N - 1));

`ifdef SUB_SEQ_OVF_EN
   logic ovf_q;
   logic ovf_d;

   assign ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_d[CHUNK-1] != a_q[WIDTH-1]);
   assign bus.ovf = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == IDLE && bus.start) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_slice) begin
         ovf_q <= ovf_d;
      end
   end
`else
   assign bus.ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q  <= RUN;
                  cnt_q    <= '0;
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  borrow_q <= bus.bin;
                  diff_q   <= '0;
                  bout_q   <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            RUN: begin
               diff_q[cnt_q*CHUNK +: CHUNK] <= sum_d[CHUNK-1:0];
               borrow_q <= ~sum_d[CHUNK];
               if (last_slice) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  bout_q  <= ~sum_d[CHUNK];
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
endmodule

// File: tb/tb_sub_seq_64.sv
// Directed-vector bench for sub_seq_64: table of operations plus hand-written
// sequences for ignored start, mid-run reset and back-to-back operation.
module tb_sub_seq_64;
   localparam int WIDTH = 64;
   localparam int LAT   = 8;

`ifdef SUB_SEQ_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sub_seq_64_if #(.WIDTH(WIDTH)) bus ();

   sub_seq_64 #(.WIDTH(WIDTH), .CHUNK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        bin;
      logic [63:0] exp_diff;
      logic        exp_bout;
      logic        exp_ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Counts cycles from the negedge just after the accepting edge until done.
   task automatic wait_done(input int elapsed, output int lat);
      lat = elapsed;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (bus.done !== 1'b1) begin
         errors++;
         checks++;
         $display("FAIL timeout: done never rose within %0d cycles", lat);
      end
   endtask

   task automatic drive_start(input logic [63:0] a, input logic [63:0] b, input logic bin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   vec_t vecs [7];

   initial begin
      int lat;
      int done_cnt;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;

      vecs[0] = '{64'h57, 64'h07, 1'b1, 64'h4F, 1'b0, 1'b0};
      vecs[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, OVF_ON};
      vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                  64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0};
      vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                  64'h8000_0000_0000_0000, 1'b1, OVF_ON};
      vecs[5] = '{64'h5, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_diff", bus.diff, 64'd0);
      check("rst_bout", {63'd0, bus.bout}, 64'd0);
      check("rst_ovf",  {63'd0, bus.ovf},  64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         drive_start(vecs[i].a, vecs[i].b, vecs[i].bin);
         check("busy_after_start", {63'd0, bus.busy}, 64'd1);
         wait_done(0, lat);
         check("latency", 64'(lat), 64'(LAT));
         check("diff", bus.diff, vecs[i].exp_diff);
         check("bout", {63'd0, bus.bout}, {63'd0, vecs[i].exp_bout});
         check("ovf",  {63'd0, bus.ovf},  {63'd0, vecs[i].exp_ovf});
         check("busy_at_done", {63'd0, bus.busy}, 64'd0);
         @(negedge clk);
         check("done_pulse", {63'd0, bus.done}, 64'd0);
         check("diff_hold", bus.diff, vecs[i].exp_diff);
         $display("op %0d: a=0x%016h b=0x%016h bin=%0b -> diff=0x%016h bout=%0b ovf=%0b lat=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].bin, bus.diff, bus.bout, bus.ovf, lat);
      end

      // start during RUN is ignored and must not disturb the latched operands
      drive_start(64'd100, 64'd30, 1'b0);
      repeat (2) @(negedge clk);
      drive_start(64'd5, 64'd9, 1'b0);
      done_cnt = 0;
      wait_done(3, lat);
      check("ign_latency", 64'(lat), 64'(LAT));
      check("ign_diff", bus.diff, 64'd70);
      check("ign_bout", {63'd0, bus.bout}, 64'd0);
      for (int k = 0; k < 12; k++) begin
         if (bus.done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      check("ign_done_once", 64'(done_cnt), 64'd1);
      check("ign_no_restart", {63'd0, bus.busy}, 64'd0);
      $display("ignored-start: diff=%0d bout=%0b done pulses=%0d", bus.diff, bus.bout, done_cnt);

      // reset in the 4th RUN cycle discards the in-flight result
      drive_start(64'd100, 64'd30, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", {63'd0, bus.busy}, 64'd0);
      check("midrst_done", {63'd0, bus.done}, 64'd0);
      check("midrst_diff", bus.diff, 64'd0);
      repeat (LAT + 2) @(negedge clk);
      check("midrst_no_done", {63'd0, bus.done}, 64'd0);
      $display("mid-run reset: busy=%0b done=%0b diff=0x%016h", bus.busy, bus.done, bus.diff);

      // rst together with start: rst wins
      rst = 1'b1;
      drive_start(64'd50, 64'd1, 1'b0);
      rst = 1'b0;
      check("rst_start_busy", {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      check("rst_start_idle", {63'd0, bus.busy}, 64'd0);
      $display("rst+start: busy=%0b", bus.busy);

      drive_start(64'd9, 64'd9, 1'b0);
      wait_done(0, lat);
      check("post_rst_latency", 64'(lat), 64'(LAT));
      check("post_rst_diff", bus.diff, 64'd0);
      check("post_rst_bout", {63'd0, bus.bout}, 64'd0);
      $display("post-reset op: diff=0x%016h bout=%0b lat=%0d", bus.diff, bus.bout, lat);
      @(negedge clk);

      // back-to-back: new start accepted in the done cycle
      drive_start(64'd10, 64'd3, 1'b0);
      wait_done(0, lat);
      check("b2b_first_diff", bus.diff, 64'd7);
      check("b2b_first_bout", {63'd0, bus.bout}, 64'd0);
      drive_start(64'd3, 64'd10, 1'b0);
      check("b2b_done_clear", {63'd0, bus.done}, 64'd0);
      check("b2b_busy", {63'd0, bus.busy}, 64'd1);
      wait_done(0, lat);
      check("b2b_latency", 64'(lat), 64'(LAT));
      check("b2b_second_diff", bus.diff, 64'hFFFF_FFFF_FFFF_FFF9);
      check("b2b_second_bout", {63'd0, bus.bout}, 64'd1);
      $display("back-to-back: diff=0x%016h bout=%0b lat=%0d", bus.diff, bus.bout, lat);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
